// File: rtl/imem_boot_sequencer_if.sv
// Program-load, imem-write and CPU-control signals between host/CPU and the boot sequencer.
interface imem_boot_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              LoadInstructions;
  logic [31:0]       Instruction;
  logic [31:0]       pc;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              cpu_run;
  logic              fetch_squash;
  logic [ADDR_W:0]   prog_len;
  logic              load_ovf;
  logic              done;
  logic              timeout;

  modport master (
    output LoadInstructions, Instruction, pc,
    input  imem_we, imem_waddr, imem_wdata, cpu_rst_n, cpu_run, fetch_squash,
           prog_len, load_ovf, done, timeout
  );

  modport slave (
    input  LoadInstructions, Instruction, pc,
    output imem_we, imem_waddr, imem_wdata, cpu_rst_n, cpu_run, fetch_squash,
           prog_len, load_ovf, done, timeout
  );
endinterface

// File: rtl/imem_boot_sequencer.sv
// Loads streamed words into imem, holds the CPU in reset for a flush period, runs it,
// drains the pipeline after fetch passes the program end, then freezes and flags done.
module imem_boot_sequencer #(
  parameter int ADDR_W       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int PIPE_DEPTH   = 5,
  parameter int MAX_CYCLES   = 1024
) (
  input logic                  clk,
  input logic                  Reset,
  imem_boot_sequencer_if.slave bus
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int          CNT_MAX = (FLUSH_CYCLES > PIPE_DEPTH) ? FLUSH_CYCLES : PIPE_DEPTH;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam int          WD_W    = $clog2(MAX_CYCLES + 1);

  localparam logic [ADDR_W:0] LEN_FULL    = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] PIPE_LAST  = CNT_W'(PIPE_DEPTH - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [WD_W-1:0]   r_wd, w_wd;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_waddr, w_waddr;
  logic [31:0]       r_wdata, w_wdata;
  logic              r_rst_n, w_rst_n;
  logic              r_run, w_run;
  logic              r_squash, w_squash;
  logic [ADDR_W:0]   r_len, w_len;
  logic              r_ovf, w_ovf;
  logic              r_done, w_done;
  logic              r_timeout, w_timeout;

  logic [ADDR_W:0]   w_pc_idx;
  logic              w_pc_oor;
  logic              w_fetch_end;
  logic              w_unused_pc_lsb;

  assign w_pc_idx        = {1'b0, bus.pc[ADDR_W+1:2]};
  assign w_pc_oor        = |bus.pc[31:ADDR_W+2];
  assign w_fetch_end     = w_pc_oor || (w_pc_idx >= r_len);
  assign w_unused_pc_lsb = ^bus.pc[1:0];

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_wd      = r_wd;
    w_we      = 1'b0;
    w_waddr   = r_waddr;
    w_wdata   = r_wdata;
    w_rst_n   = r_rst_n;
    w_run     = r_run;
    w_squash  = r_squash;
    w_len     = r_len;
    w_ovf     = r_ovf;
    w_done    = r_done;
    w_timeout = r_timeout;

    // A load request outside LOAD always (re)starts a fresh program at address 0.
    if (bus.LoadInstructions && (r_state != S_LOAD)) begin
      w_state   = S_LOAD;
      w_we      = 1'b1;
      w_waddr   = '0;
      w_wdata   = bus.Instruction;
      w_len     = (ADDR_W + 1)'(1);
      w_ovf     = 1'b0;
      w_done    = 1'b0;
      w_timeout = 1'b0;
      w_rst_n   = 1'b0;
      w_run     = 1'b0;
      w_squash  = 1'b0;
      w_cnt     = '0;
      w_wd      = '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.LoadInstructions) begin
            if (r_len == LEN_FULL) begin
              w_ovf = 1'b1;
            end else begin
              w_we    = 1'b1;
              w_waddr = r_len[ADDR_W-1:0];
              w_wdata = bus.Instruction;
              w_len   = r_len + 1'b1;
            end
          end else begin
            w_state = S_FLUSH;
            w_cnt   = '0;
            w_run   = 1'b1;
            w_rst_n = 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_cnt == FLUSH_LAST) begin
            w_state = S_RUN;
            w_rst_n = 1'b1;
            w_wd    = '0;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (w_fetch_end) begin
            w_state  = S_DRAIN;
            w_squash = 1'b1;
            w_cnt    = '0;
          end else if (r_wd == WD_LAST) begin
            w_state   = S_DONE;
            w_done    = 1'b1;
            w_timeout = 1'b1;
            w_run     = 1'b0;
          end else begin
            w_wd = r_wd + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == PIPE_LAST) begin
            w_state  = S_DONE;
            w_done   = 1'b1;
            w_run    = 1'b0;
            w_squash = 1'b0;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_rst_n   <= 1'b0;
      r_run     <= 1'b0;
      r_squash  <= 1'b0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_wd      <= w_wd;
      r_we      <= w_we;
      r_waddr   <= w_waddr;
      r_wdata   <= w_wdata;
      r_rst_n   <= w_rst_n;
      r_run     <= w_run;
      r_squash  <= w_squash;
      r_len     <= w_len;
      r_ovf     <= w_ovf;
      r_done    <= w_done;
      r_timeout <= w_timeout;
    end
  end

  assign bus.imem_we      = r_we;
  assign bus.imem_waddr   = r_waddr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.cpu_rst_n    = r_rst_n;
  assign bus.cpu_run      = r_run;
  assign bus.fetch_squash = r_squash;
  assign bus.prog_len     = r_len;
  assign bus.load_ovf     = r_ovf;
  assign bus.done         = r_done;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed scenario bench for imem_boot_sequencer with hand-computed expectations.
module tb_imem_boot_sequencer;

  logic clk;
  logic Reset;
  int   checks;
  int   errors;

  imem_boot_sequencer_if #(.ADDR_W(5)) bus ();

  imem_boot_sequencer #(
    .ADDR_W      (5),
    .FLUSH_CYCLES(2),
    .PIPE_DEPTH  (5),
    .MAX_CYCLES  (1024)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // addi/add/slt/lw/sub/sw program
  logic [31:0] prog [10] = '{
    32'h00500093, 32'h00300113, 32'h002081b3, 32'h0020a233, 32'h00302023,
    32'h00002283, 32'h40208333, 32'h00602223, 32'h00000013, 32'h00000013
  };

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [49:0] obs;
    Reset = 1'b0;
    bus.LoadInstructions = 1'b0;
    bus.Instruction = '0;
    bus.pc = '0;
    tick;
    tick;
    obs = {bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.cpu_rst_n, bus.cpu_run,
           bus.fetch_squash, bus.prog_len, bus.load_ovf, bus.done, bus.timeout};
    checks++;
    if (obs !== 50'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 50'h0);
    end
    Reset = 1'b1;
    tick;
    checks++;
    if (bus.imem_we !== 1'b0 || bus.cpu_rst_n !== 1'b0) begin
      errors++; $display("FAIL idle_hold: we=%b rst_n=%b expected we=0 rst_n=0", bus.imem_we, bus.cpu_rst_n);
    end
  endtask

  // T1: 10 words, then 2 flush cycles with cpu_rst_n low
  task automatic test_load;
    for (int i = 0; i < 10; i++) begin
      bus.LoadInstructions = 1'b1;
      bus.Instruction = prog[i];
      tick;
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 5'(i) || bus.imem_wdata !== prog[i]
          || bus.prog_len !== 6'(i + 1) || bus.cpu_rst_n !== 1'b0) begin
        errors++;
        $display("FAIL load_word[%0d]: we=%b addr=%0d data=%h len=%0d rst_n=%b expected we=1 addr=%0d data=%h len=%0d rst_n=0",
                 i, bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.prog_len, bus.cpu_rst_n, i, prog[i], i + 1);
      end
    end
    bus.LoadInstructions = 1'b0;
    tick;
    checks++;
    if (bus.imem_we !== 1'b0 || bus.cpu_rst_n !== 1'b0 || bus.cpu_run !== 1'b1 || bus.prog_len !== 6'd10) begin
      errors++; $display("FAIL flush1: we=%b rst_n=%b run=%b len=%0d expected 0 0 1 10",
                         bus.imem_we, bus.cpu_rst_n, bus.cpu_run, bus.prog_len);
    end
    tick;
    checks++;
    if (bus.cpu_rst_n !== 1'b0 || bus.cpu_run !== 1'b1) begin
      errors++; $display("FAIL flush2: rst_n=%b run=%b expected rst_n=0 run=1", bus.cpu_rst_n, bus.cpu_run);
    end
    tick;
    checks++;
    if (bus.cpu_rst_n !== 1'b1 || bus.cpu_run !== 1'b1) begin
      errors++; $display("FAIL run_entry: rst_n=%b run=%b expected 1 1", bus.cpu_rst_n, bus.cpu_run);
    end
  endtask

  // T2: fetch walks to pc=40, then 5 drain cycles and done
  task automatic test_drain;
    logic bad;
    bad = 1'b0;
    for (int j = 0; j < 10; j++) begin
      bus.pc = 32'(4 * j);
      tick;
      if (bus.fetch_squash !== 1'b0 || bus.done !== 1'b0 || bus.cpu_run !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL run_in_range: early squash/done seen=%b expected 0", bad);
    end
    bus.pc = 32'd40;
    for (int d = 0; d < 5; d++) begin
      tick;
      checks++;
      if (bus.fetch_squash !== 1'b1 || bus.cpu_run !== 1'b1 || bus.done !== 1'b0) begin
        errors++; $display("FAIL drain[%0d]: squash=%b run=%b done=%b expected 1 1 0",
                           d, bus.fetch_squash, bus.cpu_run, bus.done);
      end
    end
    tick;
    checks++;
    if (bus.done !== 1'b1 || bus.cpu_run !== 1'b0 || bus.fetch_squash !== 1'b0
        || bus.timeout !== 1'b0 || bus.cpu_rst_n !== 1'b1) begin
      errors++; $display("FAIL drain_done: done=%b run=%b squash=%b timeout=%b rst_n=%b expected 1 0 0 0 1",
                         bus.done, bus.cpu_run, bus.fetch_squash, bus.timeout, bus.cpu_rst_n);
    end
  endtask

  // T3: 33 words into a 32-word memory, then an out-of-range pc drains
  task automatic test_overflow;
    for (int i = 0; i < 33; i++) begin
      bus.LoadInstructions = 1'b1;
      bus.Instruction = 32'hA000_0000 + 32'(i);
      tick;
      if (i == 0) begin
        checks++;
        if (bus.done !== 1'b0 || bus.cpu_rst_n !== 1'b0) begin
          errors++; $display("FAIL reload_from_done: done=%b rst_n=%b expected 0 0", bus.done, bus.cpu_rst_n);
        end
      end
      if (i < 32) begin
        checks++;
        if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 5'(i) || bus.imem_wdata !== 32'hA000_0000 + 32'(i)
            || bus.prog_len !== 6'(i + 1) || bus.load_ovf !== 1'b0) begin
          errors++; $display("FAIL ovf_load[%0d]: we=%b addr=%0d data=%h len=%0d ovf=%b expected 1 %0d %h %0d 0",
                             i, bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.prog_len, bus.load_ovf,
                             i, 32'hA000_0000 + 32'(i), i + 1);
        end
      end else begin
        checks++;
        if (bus.imem_we !== 1'b0 || bus.prog_len !== 6'd32 || bus.load_ovf !== 1'b1) begin
          errors++; $display("FAIL ovf_drop: we=%b len=%0d ovf=%b expected we=0 len=32 ovf=1",
                             bus.imem_we, bus.prog_len, bus.load_ovf);
        end
      end
    end
    bus.LoadInstructions = 1'b0;
    bus.pc = 32'd0;
    tick; tick; tick;
    bus.pc = 32'h0000_0080;
    tick;
    checks++;
    if (bus.fetch_squash !== 1'b1) begin
      errors++; $display("FAIL oor_drain: squash=%b expected 1", bus.fetch_squash);
    end
    repeat (5) tick;
    checks++;
    if (bus.done !== 1'b1 || bus.load_ovf !== 1'b1 || bus.prog_len !== 6'd32) begin
      errors++; $display("FAIL ovf_done: done=%b ovf=%b len=%0d expected 1 1 32", bus.done, bus.load_ovf, bus.prog_len);
    end
  endtask

  // T4: 3 words, pc stuck at 0 -> watchdog after 1024 RUN cycles
  task automatic test_watchdog;
    logic bad;
    bus.pc = 32'd0;
    for (int i = 0; i < 3; i++) begin
      bus.LoadInstructions = 1'b1;
      bus.Instruction = 32'h0000_1000 + 32'(i);
      tick;
      if (i == 0) begin
        checks++;
        if (bus.load_ovf !== 1'b0 || bus.done !== 1'b0 || bus.imem_waddr !== 5'd0 || bus.prog_len !== 6'd1) begin
          errors++; $display("FAIL reload_clear_ovf: ovf=%b done=%b addr=%0d len=%0d expected 0 0 0 1",
                             bus.load_ovf, bus.done, bus.imem_waddr, bus.prog_len);
        end
      end
    end
    bus.LoadInstructions = 1'b0;
    tick; tick; tick;
    bad = 1'b0;
    repeat (1023) begin
      tick;
      if (bus.fetch_squash !== 1'b0 || bus.done !== 1'b0 || bus.cpu_run !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL wd_early: squash/done/stop seen=%b expected 0 within 1024 run cycles", bad);
    end
    tick;
    checks++;
    if (bus.done !== 1'b1 || bus.timeout !== 1'b1 || bus.cpu_run !== 1'b0 || bus.fetch_squash !== 1'b0) begin
      errors++; $display("FAIL wd_done: done=%b timeout=%b run=%b squash=%b expected 1 1 0 0",
                         bus.done, bus.timeout, bus.cpu_run, bus.fetch_squash);
    end
  endtask

  // T5: reload from DONE clears timeout; single-cycle load abort in RUN
  task automatic test_abort;
    bus.LoadInstructions = 1'b1;
    bus.Instruction = 32'h1111_1111;
    tick;
    checks++;
    if (bus.timeout !== 1'b0 || bus.done !== 1'b0 || bus.prog_len !== 6'd1 || bus.imem_waddr !== 5'd0) begin
      errors++; $display("FAIL reload_clear_to: timeout=%b done=%b len=%0d addr=%0d expected 0 0 1 0",
                         bus.timeout, bus.done, bus.prog_len, bus.imem_waddr);
    end
    bus.Instruction = 32'h2222_2222;
    tick;
    bus.LoadInstructions = 1'b0;
    bus.pc = 32'd0;
    tick; tick; tick; tick;
    checks++;
    if (bus.cpu_rst_n !== 1'b1 || bus.cpu_run !== 1'b1) begin
      errors++; $display("FAIL abort_pre_run: rst_n=%b run=%b expected 1 1", bus.cpu_rst_n, bus.cpu_run);
    end
    bus.LoadInstructions = 1'b1;
    bus.Instruction = 32'hDEAD_BEEF;
    tick;
    bus.LoadInstructions = 1'b0;
    checks++;
    if (bus.cpu_rst_n !== 1'b0 || bus.imem_we !== 1'b1 || bus.imem_waddr !== 5'd0
        || bus.imem_wdata !== 32'hDEAD_BEEF || bus.prog_len !== 6'd1 || bus.cpu_run !== 1'b0) begin
      errors++; $display("FAIL abort_run: rst_n=%b we=%b addr=%0d data=%h len=%0d run=%b expected 0 1 0 deadbeef 1 0",
                         bus.cpu_rst_n, bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.prog_len, bus.cpu_run);
    end
  endtask

  // T6: reset mid-load (prog_len=4) and mid-drain
  task automatic test_reset_midway;
    logic [49:0] obs;
    for (int i = 1; i < 4; i++) begin
      bus.LoadInstructions = 1'b1;
      bus.Instruction = 32'h3333_0000 + 32'(i);
      tick;
    end
    checks++;
    if (bus.prog_len !== 6'd4 || bus.imem_waddr !== 5'd3) begin
      errors++; $display("FAIL pre_reset_len: len=%0d addr=%0d expected 4 3", bus.prog_len, bus.imem_waddr);
    end
    Reset = 1'b0;
    tick;
    obs = {bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.cpu_rst_n, bus.cpu_run,
           bus.fetch_squash, bus.prog_len, bus.load_ovf, bus.done, bus.timeout};
    checks++;
    if (obs !== 50'h0) begin
      errors++; $display("FAIL reset_in_load: got %h expected %h", obs, 50'h0);
    end
    tick;
    checks++;
    if (bus.imem_we !== 1'b0) begin
      errors++; $display("FAIL reset_priority: we=%b expected 0", bus.imem_we);
    end
    Reset = 1'b1;
    bus.LoadInstructions = 1'b0;
    tick;
    checks++;
    if (bus.imem_we !== 1'b0 || bus.prog_len !== 6'd0 || bus.cpu_run !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: we=%b len=%0d run=%b expected 0 0 0",
                         bus.imem_we, bus.prog_len, bus.cpu_run);
    end
    bus.pc = 32'd0;
    for (int i = 0; i < 2; i++) begin
      bus.LoadInstructions = 1'b1;
      bus.Instruction = 32'h4444_0000 + 32'(i);
      tick;
    end
    bus.LoadInstructions = 1'b0;
    tick; tick; tick;
    bus.pc = 32'd8;
    tick;
    checks++;
    if (bus.fetch_squash !== 1'b1) begin
      errors++; $display("FAIL drain_before_reset: squash=%b expected 1", bus.fetch_squash);
    end
    tick;
    Reset = 1'b0;
    tick;
    obs = {bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.cpu_rst_n, bus.cpu_run,
           bus.fetch_squash, bus.prog_len, bus.load_ovf, bus.done, bus.timeout};
    checks++;
    if (obs !== 50'h0) begin
      errors++; $display("FAIL reset_in_drain: got %h expected %h", obs, 50'h0);
    end
    Reset = 1'b1;
    tick;
    checks++;
    if (bus.imem_we !== 1'b0 || bus.cpu_run !== 1'b0 || bus.cpu_rst_n !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL idle_after_drain_reset: we=%b run=%b rst_n=%b done=%b expected 0 0 0 0",
                         bus.imem_we, bus.cpu_run, bus.cpu_rst_n, bus.done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b0;
    bus.LoadInstructions = 1'b0;
    bus.Instruction = '0;
    bus.pc = '0;
    test_reset;
    test_load;
    test_drain;
    test_overflow;
    test_watchdog;
    test_abort;
    test_reset_midway;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
